masked_round_controller: RTL and testbench

Parametrised round/stage sequencer for the masked low-latency block-cipher cores (Midori64 and future variants).
- Generalises fixed 16-round, fixed-stage counting to configurable round count and S-box pipeline depth.
- Adds a start/busy/done handshake, a per-stage fresh-randomness handshake that stalls the datapath, and a last-round flag.
- Drives the state-register enable, plaintext/key load select and round-constant index of the cipher datapath.

---
 rtl/masked_round_controller.sv | 98 +++++++++
 tb/tb_masked_round_controller.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/masked_round_controller.sv
// Round/stage sequencer for masked low-latency block-cipher cores.
// Steps through NUM_ROUNDS rounds of SBOX_STAGES register stages each, stalling
// on every stage until fresh mask randomness is available.
module masked_round_controller #(
    parameter int unsigned NUM_ROUNDS  = 16,
    parameter int unsigned SBOX_STAGES = 2,
    parameter int unsigned ROUND_W     = 4,
    parameter int unsigned STAGE_W     = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               rand_ready,
    output logic               rand_req,
    output logic [ROUND_W-1:0] round,
    output logic [STAGE_W-1:0] stage,
    output logic               round_start_select,
    output logic               last_round,
    output logic               en,
    output logic               busy,
    output logic               done
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StLoad = 2'd1;
    localparam logic [1:0] StRun  = 2'd2;
    localparam logic [1:0] StDone = 2'd3;

    localparam logic [ROUND_W-1:0] LastRound = ROUND_W'(NUM_ROUNDS - 1);
    localparam logic [STAGE_W-1:0] LastStage = STAGE_W'(SBOX_STAGES - 1);

    logic [1:0]         state_q, state_d;
    logic [ROUND_W-1:0] round_q, round_d;
    logic [STAGE_W-1:0] stage_q, stage_d;

    // Next-state and counter update; counters only move on an advance in RUN.
    always_comb begin
        state_d = state_q;
        round_d = round_q;
        stage_d = stage_q;
        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = StLoad;
                    round_d = '0;
                    stage_d = '0;
                end
            end
            StLoad: begin
                state_d = StRun;
            end
            StRun: begin
                if (rand_ready) begin
                    if (stage_q == LastStage) begin
                        stage_d = '0;
                        // Final advance leaves round parked at the last index.
                        if (round_q == LastRound) begin
                            state_d = StDone;
                        end else begin
                            round_d = round_q + ROUND_W'(1);
                        end
                    end else begin
                        stage_d = stage_q + STAGE_W'(1);
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and counter registers with asynchronous abort.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            round_q <= '0;
            stage_q <= '0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            stage_q <= stage_d;
        end
    end

    // Output decodes; all pure functions of state, counters and rand_ready.
    always_comb begin
        round_start_select = (state_q == StLoad);
        rand_req           = (state_q == StRun);
        en                 = (state_q == StLoad) || ((state_q == StRun) && rand_ready);
        busy               = (state_q == StLoad) || (state_q == StRun);
        done               = (state_q == StDone);
        last_round         = (state_q == StRun) && (round_q == LastRound);
        round              = round_q;
        stage              = stage_q;
    end

endmodule

// File: tb/tb_masked_round_controller.sv
// Directed bench for masked_round_controller: default 16x2 instance plus a 12x3 instance.
module tb_masked_round_controller;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    // Default configuration instance
    logic       a_start, a_rr, a_req, a_rss, a_last, a_en, a_busy, a_done;
    logic [3:0] a_round;
    logic [1:0] a_stage;

    // 12 rounds x 3 stages instance
    logic       b_start, b_rr, b_req, b_rss, b_last, b_en, b_busy, b_done;
    logic [3:0] b_round;
    logic [1:0] b_stage;

    int total = 0;
    int bad = 0;

    masked_round_controller #(
        .NUM_ROUNDS (16),
        .SBOX_STAGES(2),
        .ROUND_W    (4),
        .STAGE_W    (2)
    ) dut_a (
        .clk               (clk),
        .reset_n           (reset_n),
        .start             (a_start),
        .rand_ready        (a_rr),
        .rand_req          (a_req),
        .round             (a_round),
        .stage             (a_stage),
        .round_start_select(a_rss),
        .last_round        (a_last),
        .en                (a_en),
        .busy              (a_busy),
        .done              (a_done)
    );

    masked_round_controller #(
        .NUM_ROUNDS (12),
        .SBOX_STAGES(3),
        .ROUND_W    (4),
        .STAGE_W    (2)
    ) dut_b (
        .clk               (clk),
        .reset_n           (reset_n),
        .start             (b_start),
        .rand_ready        (b_rr),
        .rand_req          (b_req),
        .round             (b_round),
        .stage             (b_stage),
        .round_start_select(b_rss),
        .last_round        (b_last),
        .en                (b_en),
        .busy              (b_busy),
        .done              (b_done)
    );

    // Flag vectors below are ordered {round_start_select, en, busy, done, rand_req, last_round}.

    task automatic test_reset();
        a_start = 1'b0; a_rr = 1'b0;
        b_start = 1'b0; b_rr = 1'b0;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({a_rss, a_en, a_busy, a_done, a_req, a_last, a_round, a_stage} !== 12'd0) begin
            bad++;
            $display("FAIL reset_hold: got flags=%b round=%0d stage=%0d want all 0",
                     {a_rss, a_en, a_busy, a_done, a_req, a_last}, a_round, a_stage);
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            total++;
            if ({a_rss, a_en, a_busy, a_done, a_req, a_last} !== 6'b000000) begin
                bad++;
                $display("FAIL idle_flags_a cycle %0d: got %b want 000000", c,
                         {a_rss, a_en, a_busy, a_done, a_req, a_last});
            end
            total++;
            if ({a_round, a_stage} !== 6'd0) begin
                bad++;
                $display("FAIL idle_cnt_a cycle %0d: got round=%0d stage=%0d want 0/0", c,
                         a_round, a_stage);
            end
            total++;
            if ({b_rss, b_en, b_busy, b_done, b_req, b_last, b_round, b_stage} !== 12'd0) begin
                bad++;
                $display("FAIL idle_b cycle %0d: got flags=%b round=%0d stage=%0d want all 0",
                         c, {b_rss, b_en, b_busy, b_done, b_req, b_last}, b_round, b_stage);
            end
        end
    endtask

    // One operation on the default instance; rand_ready low for stall_len cycles from stall_at.
    task automatic test_default(input int stall_at, input int stall_len, input string name);
        int         done_cycle;
        int         adv;
        int         en_cnt;
        logic [5:0] exp_f;
        logic [3:0] exp_r;
        logic [1:0] exp_s;
        done_cycle = 34 + stall_len;
        adv = 0;
        en_cnt = 0;
        @(posedge clk);
        #1;
        a_start = 1'b1;
        a_rr = 1'b1;
        for (int c = 1; c <= done_cycle + 2; c++) begin
            @(posedge clk);
            #1;
            a_start = 1'b0;
            a_rr = (c >= stall_at && c < stall_at + stall_len) ? 1'b0 : 1'b1;
            #1;
            if (c == 1) begin
                exp_f = 6'b111000; exp_r = 4'd0; exp_s = 2'd0;
            end else if (c < done_cycle) begin
                exp_r = 4'(adv / 2);
                exp_s = 2'(adv % 2);
                exp_f = {1'b0, a_rr, 1'b1, 1'b0, 1'b1, (exp_r == 4'd15)};
            end else begin
                exp_f = 6'b000100; exp_r = 4'd15; exp_s = 2'd0;
            end
            total++;
            if ({a_rss, a_en, a_busy, a_done, a_req, a_last} !== exp_f) begin
                bad++;
                $display("FAIL %s flags cycle %0d: got %b want %b", name, c,
                         {a_rss, a_en, a_busy, a_done, a_req, a_last}, exp_f);
            end
            total++;
            if ({a_round, a_stage} !== {exp_r, exp_s}) begin
                bad++;
                $display("FAIL %s count cycle %0d: got round=%0d stage=%0d want %0d/%0d",
                         name, c, a_round, a_stage, exp_r, exp_s);
            end
            if (a_en === 1'b1) en_cnt++;
            if (c >= 2 && c < done_cycle && a_rr) adv++;
        end
        total++;
        if (en_cnt != 33) begin
            bad++;
            $display("FAIL %s en_count: got %0d want 33", name, en_cnt);
        end
    endtask

    task automatic test_alt_config();
        int         adv;
        int         en_cnt;
        int         max_round;
        logic [5:0] exp_f;
        logic [3:0] exp_r;
        logic [1:0] exp_s;
        adv = 0;
        en_cnt = 0;
        max_round = 0;
        @(posedge clk);
        #1;
        b_start = 1'b1;
        b_rr = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            b_start = 1'b0;
            #1;
            if (c == 1) begin
                exp_f = 6'b111000; exp_r = 4'd0; exp_s = 2'd0;
            end else if (c < 38) begin
                exp_r = 4'(adv / 3);
                exp_s = 2'(adv % 3);
                exp_f = {1'b0, 1'b1, 1'b1, 1'b0, 1'b1, (exp_r == 4'd11)};
                adv++;
            end else begin
                exp_f = 6'b000100; exp_r = 4'd11; exp_s = 2'd0;
            end
            total++;
            if ({b_rss, b_en, b_busy, b_done, b_req, b_last} !== exp_f) begin
                bad++;
                $display("FAIL alt flags cycle %0d: got %b want %b", c,
                         {b_rss, b_en, b_busy, b_done, b_req, b_last}, exp_f);
            end
            total++;
            if ({b_round, b_stage} !== {exp_r, exp_s}) begin
                bad++;
                $display("FAIL alt count cycle %0d: got round=%0d stage=%0d want %0d/%0d",
                         c, b_round, b_stage, exp_r, exp_s);
            end
            if (b_en === 1'b1) en_cnt++;
            if (int'(b_round) > max_round) max_round = int'(b_round);
        end
        total++;
        if (en_cnt != 37) begin
            bad++;
            $display("FAIL alt en_count: got %0d want 37", en_cnt);
        end
        total++;
        if (max_round != 11) begin
            bad++;
            $display("FAIL alt max_round: got %0d want 11", max_round);
        end
    endtask

    // start held high across two operations: ignored while busy, restarts straight from DONE.
    task automatic test_start_held();
        int         p;
        logic [5:0] exp_f;
        logic [3:0] exp_r;
        logic [1:0] exp_s;
        @(posedge clk);
        #1;
        a_start = 1'b1;
        a_rr = 1'b1;
        for (int c = 1; c <= 68; c++) begin
            @(posedge clk);
            #1;
            if (c == 68) a_start = 1'b0;
            #1;
            p = ((c - 1) % 34) + 1;
            if (p == 1) begin
                exp_f = 6'b111000; exp_r = 4'd0; exp_s = 2'd0;
            end else if (p < 34) begin
                exp_r = 4'((p - 2) / 2);
                exp_s = 2'((p - 2) % 2);
                exp_f = {1'b0, 1'b1, 1'b1, 1'b0, 1'b1, (exp_r == 4'd15)};
            end else begin
                exp_f = 6'b000100; exp_r = 4'd15; exp_s = 2'd0;
            end
            total++;
            if ({a_rss, a_en, a_busy, a_done, a_req, a_last} !== exp_f) begin
                bad++;
                $display("FAIL held flags cycle %0d: got %b want %b", c,
                         {a_rss, a_en, a_busy, a_done, a_req, a_last}, exp_f);
            end
            total++;
            if ({a_round, a_stage} !== {exp_r, exp_s}) begin
                bad++;
                $display("FAIL held count cycle %0d: got round=%0d stage=%0d want %0d/%0d",
                         c, a_round, a_stage, exp_r, exp_s);
            end
        end
        // With start released the controller must sit in DONE.
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({a_rss, a_en, a_busy, a_done, a_req, a_last} !== 6'b000100) begin
            bad++;
            $display("FAIL held park: got %b want 000100",
                     {a_rss, a_en, a_busy, a_done, a_req, a_last});
        end
    endtask

    task automatic test_reset_mid();
        @(posedge clk);
        #1;
        a_start = 1'b1;
        a_rr = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            @(posedge clk);
            #1;
            a_start = 1'b0;
        end
        #1;
        total++;
        if ({a_round, a_stage, a_busy} !== {4'd7, 2'd0, 1'b1}) begin
            bad++;
            $display("FAIL mid_pre: got round=%0d stage=%0d busy=%b want 7/0/1",
                     a_round, a_stage, a_busy);
        end
        #1;
        reset_n = 1'b0;
        #1;
        total++;
        if ({a_rss, a_en, a_busy, a_done, a_req, a_last, a_round, a_stage} !== 12'd0) begin
            bad++;
            $display("FAIL mid_reset: got flags=%b round=%0d stage=%0d want all 0",
                     {a_rss, a_en, a_busy, a_done, a_req, a_last}, a_round, a_stage);
        end
        @(posedge clk);
        #1;
        total++;
        if ({a_rss, a_en, a_busy, a_done, a_req, a_last, a_round, a_stage} !== 12'd0) begin
            bad++;
            $display("FAIL mid_reset_hold: got flags=%b round=%0d stage=%0d want all 0",
                     {a_rss, a_en, a_busy, a_done, a_req, a_last}, a_round, a_stage);
        end
        @(negedge clk);
        reset_n = 1'b1;
        test_default(-1, 0, "post_reset");
    endtask

    initial begin
        test_reset();
        test_default(-1, 0, "nominal");
        test_default(13, 3, "stall");
        test_alt_config();
        test_start_held();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
